// File: rtl/resp_pkg.sv
// Shared types and default sizes for the serial response transmitter.
package resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    DONE
  } resp_state_t;

  localparam int RESP_DATA_W     = 8;
  localparam int RESP_FIFO_DEPTH = 4;

endpackage

// File: rtl/resp_tx_if.sv
// Word-in / serial-out handshake bundle for resp_tx; slave is the transmitter's view.
interface resp_tx_if
  import resp_pkg::*;
#(
  parameter int DATA_W = RESP_DATA_W
);

  logic [DATA_W-1:0] word_in;
  logic              word_vld;
  logic              word_rdy;
  logic              tx_data;
  logic              tx_vld;
  logic              rx_ready;
  logic              tx_finish;

  modport master (
    output word_in, word_vld, rx_ready,
    input  word_rdy, tx_data, tx_vld, tx_finish
  );

  modport slave (
    input  word_in, word_vld, rx_ready,
    output word_rdy, tx_data, tx_vld, tx_finish
  );

endinterface

// File: rtl/resp_fifo.sv
// Small synchronous FIFO with show-ahead head word and async active-low clear.
module resp_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int                 PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]     FULL_CNT = DEPTH[PTR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries data only, so it is left out of the clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/resp_tx.sv
// Serial response transmitter: buffers words and sends each LSB-first plus an even-parity bit.
module resp_tx
  import resp_pkg::*;
#(
  parameter int DATA_W     = RESP_DATA_W,
  parameter int FIFO_DEPTH = RESP_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      clr,
  resp_tx_if.slave  bus
);

  localparam int                 CNT_W    = $clog2(DATA_W);
  localparam int                 LAST     = DATA_W - 1;
  localparam logic [CNT_W-1:0]   LAST_BIT = LAST[CNT_W-1:0];

  resp_state_t       state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] sr;
  logic              par;
  logic              tx_vld_q;
  logic              tx_data_q;
  logic              tx_finish_q;

  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              load;
  logic              shift_en;

  assign load     = (state == IDLE) && !fifo_empty;
  assign shift_en = (state == SHIFT) && bus.rx_ready;

  resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (bus.word_vld),
    .pop   (load),
    .din   (bus.word_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Bit 0 goes straight to tx_data at load time, so sr only holds the bits still to come.
  always_ff @(posedge clk) begin
    if (load) begin
      sr  <= fifo_dout[DATA_W-1:1];
      par <= ^fifo_dout;
    end else if (shift_en) begin
      sr  <= sr >> 1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      tx_vld_q    <= 1'b0;
      tx_data_q   <= 1'b0;
      tx_finish_q <= 1'b0;
    end else begin
      tx_finish_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            tx_vld_q  <= 1'b1;
            tx_data_q <= fifo_dout[0];
          end
        end
        SHIFT: begin
          if (bus.rx_ready) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state     <= PARITY;
              tx_data_q <= par;
            end else begin
              tx_data_q <= sr[0];
            end
          end
        end
        PARITY: begin
          if (bus.rx_ready) begin
            state       <= DONE;
            tx_vld_q    <= 1'b0;
            tx_data_q   <= 1'b0;
            tx_finish_q <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_vld    = tx_vld_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_finish = tx_finish_q;
  assign bus.word_rdy  = !fifo_full;

endmodule
